stream_pattern_source: RTL
==========================

// Module: stream_pattern_source
// PURPOSE
//  Synthesizable valid/ready stimulus stage. It sits directly downstream of the
//  testbench clock-domain generator and consumes its CLK, RST and EN.
//  After EN rises it emits a deterministic arithmetic word sequence. An
//  LFSR-driven throttle inserts valid gaps. The stream feeds the DUT input port.
// PARAMETERS
//  WIDTH     32       data width in bits, >=1
//  NUM_WORDS 16       words per run, >=1 (0 is an elaboration error)
//  START     0        first data word
//  STEP      1        increment between words, applied modulo 2^WIDTH
//  THROTTLE  0        gap density 0..7; 0 = no gaps, 7 = gap on 7 of 8 LFSR states
//  SEED      16'hACE1 LFSR reset value, must be nonzero
// PORTS
//  CLK      in   1      clock, rising edge
//  RST      in   1      synchronous reset, active-low (RST==0 at posedge resets)
//  EN       in   1      run enable / start request from the clock domain
//  I_READY  in   1      downstream ready
//  O_VALID  out  1      data valid
//  O_DATA   out  WIDTH  payload = START + idx*STEP (mod 2^WIDTH)
//  O_LAST   out  1      high with the word idx==NUM_WORDS-1
//  O_DONE   out  1      sticky, set after the last handshake
//  O_COUNT  out  32     number of completed handshakes
// BEHAVIOUR
//  Reset values: O_VALID=0, O_DATA=START, O_LAST=0, O_DONE=0, O_COUNT=0,
//   idx=0, lfsr=SEED, state=IDLE. Reset has priority over every other event.
//  Handshake: hs = O_VALID & I_READY at a posedge.
//  FSM:
//   IDLE -> RUN when EN==1 at a posedge. The earliest O_VALID is the next cycle.
//   RUN  -> DONE on the hs where idx==NUM_WORDS-1.
//   DONE is absorbing. O_DONE=1 and O_VALID=0 until reset.
//  RUN, valid raise: when O_VALID==0 and EN==1, set O_VALID=1 if
//   lfsr[2:0] >= THROTTLE, else leave it 0 for that cycle.
//  RUN, valid hold: once O_VALID=1, O_VALID, O_DATA and O_LAST are stable
//   until hs. They are never withdrawn. The LFSR and EN are ignored while a
//   word is pending.
//  On hs: idx+=1, O_DATA+=STEP (wraps at 2^WIDTH), O_COUNT+=1.
//   O_VALID may re-raise in the cycle after hs, giving back-to-back words at
//   THROTTLE=0. O_LAST is recomputed for the new idx.
//  O_LAST is 1 only while O_VALID=1 and idx==NUM_WORDS-1.
//   NUM_WORDS==1: the first word carries O_LAST.
//  EN low during RUN pauses the stream: no new raise, a pending word is held.
//   EN high resumes without restarting idx.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle in RUN,
//   including stalled cycles, and freezes in IDLE and DONE.
//  O_COUNT wraps at 2^32 and never saturates.
//  Reset mid-RUN with a pending word: O_VALID drops next cycle, no hs is counted.
// STRUCTURE
//  Shared header stream_pkg.vh: FSM encodings (IDLE=2'd0, RUN=2'd1,
//   DONE=2'd2) and LFSR_W=16 with its tap mask.
//  Sub-module lfsr16 (ports CLK, RST, EN_STEP, SEED, Q), reusable by sinks.
//  Top-level logic: FSM, idx counter, data accumulator, valid/last registers.
// TESTING
//  T1 THROTTLE=0, I_READY=1, EN from cycle 2: data 0..15 on 16 consecutive
//   cycles, O_LAST only on 15, O_DONE=1 the cycle after, O_COUNT=16.
//  T2 I_READY low for 5 cycles while O_VALID=1, word 3: O_DATA stays 3 and
//   O_VALID stays 1 every cycle. Word 4 follows hs.
//  T3 START=32'hFFFF_FFFE, STEP=1, NUM_WORDS=4: FFFFFFFE, FFFFFFFF, 0, 1 in
//   that order. O_LAST with word 1.
//  T4 THROTTLE=7, SEED default: gap count matches the reference-model LFSR
//   cycle for cycle. All 16 words are delivered in order.
//  T5 EN low after 5 hs, 10 cycles, then high: pending word held, no new raise.
//   idx resumes at 5. O_COUNT ends at 16.
//  T6 RST=0 for one cycle at word 7 with O_VALID=1: all outputs at reset values.
//   The next EN restarts from START. NUM_WORDS=1 case: first word has O_LAST.

Source files
------------

// File: rtl/stream_pattern_source_pkg.sv
// Shared definitions for the pattern source: FSM encoding, LFSR geometry and
// the throttle slot test.
package stream_pattern_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register (bits 0,2,3,5)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  function automatic logic slot_open(input logic [2:0] rnd, input logic [2:0] thr);
    return rnd >= thr;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous active-low reset to SEED; steps only
// when EN_STEP is high so callers can freeze it outside their active window.
module lfsr16
  import stream_pattern_source_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN_STEP,
  input  logic [LFSR_W-1:0] SEED,
  output logic [LFSR_W-1:0] Q
);

  logic fb;

  assign fb = ^(Q & LFSR_TAPS);

  always_ff @(posedge CLK) begin
    if (!RST) Q <= SEED;
    else if (EN_STEP) Q <= {fb, Q[LFSR_W-1:1]};
  end

endmodule

// File: rtl/stream_pattern_source.sv
// Valid/ready word source: emits START + idx*STEP for NUM_WORDS words after EN,
// with LFSR-driven valid gaps controlled by THROTTLE.
//
// state   | meaning
// IDLE    | waiting for EN, outputs at reset values
// RUN     | streaming words, LFSR stepping every cycle
// DONE    | all words handshaken, O_DONE sticky until reset
module stream_pattern_source
  import stream_pattern_source_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter int                NUM_WORDS = 16,
  parameter logic [WIDTH-1:0]  START     = '0,
  parameter logic [WIDTH-1:0]  STEP      = WIDTH'(1),
  parameter int                THROTTLE  = 0,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             I_READY,
  output logic             O_VALID,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_LAST,
  output logic             O_DONE,
  output logic [31:0]      O_COUNT
);

  if (NUM_WORDS < 1 || SEED == '0) begin : g_param_check
    $error("stream_pattern_source: NUM_WORDS must be >= 1 and SEED nonzero");
  end

  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);
  localparam logic [2:0]  THR3     = 3'(THROTTLE);

  state_t             state, state_nxt;
  logic [31:0]        idx, idx_nxt;
  logic [31:0]        count_nxt;
  logic [WIDTH-1:0]   data_nxt;
  logic               valid_nxt, last_nxt, done_nxt;
  logic               hs;
  logic [LFSR_W-1:0]  lfsr_q;
  logic               unused_lfsr_hi;

  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:3];
  assign hs = O_VALID & I_READY;

  lfsr16 u_lfsr (
    .CLK     (CLK),
    .RST     (RST),
    .EN_STEP (state == ST_RUN),
    .SEED    (SEED),
    .Q       (lfsr_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= ST_IDLE;
      idx     <= '0;
      O_VALID <= 1'b0;
      O_DATA  <= START;
      O_LAST  <= 1'b0;
      O_DONE  <= 1'b0;
      O_COUNT <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      O_VALID <= valid_nxt;
      O_DATA  <= data_nxt;
      O_LAST  <= last_nxt;
      O_DONE  <= done_nxt;
      O_COUNT <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = O_DATA;
    count_nxt = O_COUNT;
    valid_nxt = O_VALID;
    last_nxt  = O_LAST;
    done_nxt  = O_DONE;
    case (state)
      ST_IDLE: begin
        if (EN) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (hs) begin
          idx_nxt   = idx + 32'd1;
          data_nxt  = O_DATA + STEP;
          count_nxt = O_COUNT + 32'd1;
        end
        if (hs && idx == LAST_IDX) begin
          state_nxt = ST_DONE;
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (!O_VALID || hs) begin
          // a free slot (nothing pending, or just accepted) may be refilled at once
          valid_nxt = EN && slot_open(lfsr_q[2:0], THR3);
          last_nxt  = valid_nxt && (idx_nxt == LAST_IDX);
        end
      end
      ST_DONE: begin
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
